// File: rtl/tlc_pkg.sv
// tlc_pkg: state codes and uo_out lamp bit positions for the traffic light controller
package tlc_pkg;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;
  localparam int L_NS_RED    = 0;
  localparam int L_NS_YELLOW = 1;
  localparam int L_NS_GREEN  = 2;
  localparam int L_EW_RED    = 3;
  localparam int L_EW_YELLOW = 4;
  localparam int L_EW_GREEN  = 5;
  localparam int L_WALK      = 6;
  localparam int L_PED       = 7;
endpackage

// File: rtl/tlc_prescaler.sv
// tlc_prescaler: divides clk into a one-cycle tick every TICK_DIV enabled cycles
module tlc_prescaler #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] count;
  assign tick = count == W'(TICK_DIV - 1);
  always_ff @(posedge clk)
    if (!rst_n) count <= '0;
    else if (ena) count <= (clr || tick) ? '0 : count + W'(1);
endmodule

// File: rtl/tt_um_tlc.sv
// tt_um_tlc: TinyTapeout tile wrapper around traffic_light_ctrl with default timing
module tt_um_tlc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  traffic_light_ctrl u_tlc (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection FSM with pedestrian walk and flashing-yellow mode
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int TICK_DIV   = 10,
  parameter int T_NS_GREEN = 10,
  parameter int T_EW_GREEN = 6,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 1,
  parameter int T_WALK     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  state_t state, next;
  logic [3:0] timer, load;
  logic ped, phase, tick, leave, flash, ns_g, ns_y, ew_g, ew_y, unused;
  assign unused = ^{uio_in, ui_in[7:3]};
  tlc_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clr(leave), .tick(tick)
  );
  always_comb begin
    next = state;
    if (state != FLASH && ui_in[2]) next = FLASH;
    else if (state == FLASH) next = (tick && !ui_in[2]) ? ALLRED_B : FLASH;
    else if (tick && timer == 4'd1)
      case (state)
        NS_GREEN:  next = (ui_in[0] || ped) ? NS_YELLOW : NS_GREEN;
        NS_YELLOW: next = ALLRED_A;
        ALLRED_A:  next = EW_GREEN;
        EW_GREEN:  next = EW_YELLOW;
        EW_YELLOW: next = ALLRED_B;
        ALLRED_B:  next = ped ? PED_WALK : NS_GREEN;
        default:   next = NS_GREEN;
      endcase
  end
  // every state change restarts the prescaler and reloads the timer
  assign leave = next != state;
  assign load = next == NS_GREEN ? 4'(T_NS_GREEN) :
                next == EW_GREEN ? 4'(T_EW_GREEN) :
                (next == NS_YELLOW || next == EW_YELLOW) ? 4'(T_YELLOW) :
                (next == ALLRED_A || next == ALLRED_B) ? 4'(T_ALLRED) :
                next == PED_WALK ? 4'(T_WALK) : 4'd0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= ALLRED_B;
      timer <= 4'(T_ALLRED);
      ped   <= 1'b0;
      phase <= 1'b0;
    end else if (ena) begin
      state <= next;
      timer <= leave ? load : (tick && timer > 4'd1) ? timer - 4'd1 : timer;
      ped   <= (next == PED_WALK && state != PED_WALK) ? 1'b0 : ped | ui_in[1];
      phase <= (next == FLASH) && (state != FLASH || (phase ^ tick));
    end
  assign flash = state == FLASH;
  assign ns_g = state == NS_GREEN;
  assign ns_y = state == NS_YELLOW || (flash && phase);
  assign ew_g = state == EW_GREEN;
  assign ew_y = state == EW_YELLOW || (flash && phase);
  always_comb begin
    uo_out = '0;
    uo_out[L_NS_RED]    = !(ns_g || ns_y || flash);
    uo_out[L_NS_YELLOW] = ns_y;
    uo_out[L_NS_GREEN]  = ns_g;
    uo_out[L_EW_RED]    = !(ew_g || ew_y || flash);
    uo_out[L_EW_YELLOW] = ew_y;
    uo_out[L_EW_GREEN]  = ew_g;
    uo_out[L_WALK]      = state == PED_WALK;
    uo_out[L_PED]       = ped;
  end
  assign uio_out = {timer, 1'b0, state};
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: scoreboard bench; expectations queued at drive time, checked on negedge
module tb_traffic_light_ctrl;
  typedef struct {string name; logic [7:0] uo; logic [7:0] uio;} exp_t;
  typedef struct {string name; logic [7:0] ui; int wait_cyc; logic [7:0] uo; logic [7:0] uio;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  exp_t sb[$];
  exp_t cur;
  vec_t vecs[6];
  int compared = 0, mismatched = 0;
  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string name, input logic [7:0] uo, input logic [7:0] uio);
    sb.push_back('{name, uo, uio});
  endtask
  always @(negedge clk)
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      compared += 2;
      if (uo_out !== cur.uo) begin
        mismatched++;
        $display("FAIL %s uo_out got %h want %h", cur.name, uo_out, cur.uo);
      end
      if (uio_out !== cur.uio) begin
        mismatched++;
        $display("FAIL %s uio_out got %h want %h", cur.name, uio_out, cur.uio);
      end
    end
  initial begin
    vecs[0] = '{"ns_yellow", 8'h01, 10, 8'h0A, 8'h31};
    vecs[1] = '{"allred_a",  8'h00, 30, 8'h09, 8'h12};
    vecs[2] = '{"ew_green",  8'h00, 10, 8'h21, 8'h63};
    vecs[3] = '{"ew_yellow", 8'h00, 60, 8'h11, 8'h34};
    vecs[4] = '{"allred_b",  8'h00, 30, 8'h09, 8'h15};
    vecs[5] = '{"ns_green",  8'h00, 10, 8'h0C, 8'hA0};
    cyc(5);
    expect_out("reset", 8'h09, 8'h15);
    compared++;
    if (uio_oe !== 8'hFF) begin
      mismatched++;
      $display("FAIL uio_oe got %h want ff", uio_oe);
    end
    rst_n = 1'b1;
    cyc(10);
    expect_out("first_ns_green", 8'h0C, 8'hA0);
    cyc(50);
    expect_out("ns_countdown", 8'h0C, 8'h50);
    cyc(45);
    expect_out("ns_timer_floor", 8'h0C, 8'h10);
    cyc(205);
    expect_out("no_demand_hold", 8'h0C, 8'h10);
    foreach (vecs[i]) begin
      ui_in = vecs[i].ui;
      cyc(vecs[i].wait_cyc);
      expect_out(vecs[i].name, vecs[i].uo, vecs[i].uio);
    end
    // pedestrian request during EW green, with an ena freeze mid-phase
    ui_in = 8'h01;
    cyc(100);
    expect_out("ped_ns_yellow", 8'h0A, 8'h31);
    ui_in = 8'h00;
    cyc(40);
    expect_out("ped_ew_green", 8'h21, 8'h63);
    cyc(20);
    ui_in = 8'h02;
    cyc(1);
    ui_in = 8'h00;
    expect_out("ped_latched", 8'hA1, 8'h43);
    ena = 1'b0;
    cyc(50);
    expect_out("ena_hold_a", 8'hA1, 8'h43);
    cyc(50);
    expect_out("ena_hold_b", 8'hA1, 8'h43);
    ena = 1'b1;
    cyc(38);
    expect_out("resume_last", 8'hA1, 8'h13);
    cyc(1);
    expect_out("resume_ew_yellow", 8'h91, 8'h34);
    cyc(30);
    expect_out("ped_allred_b", 8'h89, 8'h15);
    cyc(10);
    expect_out("walk_entry", 8'h49, 8'h56);
    cyc(49);
    expect_out("walk_last", 8'h49, 8'h16);
    cyc(1);
    expect_out("walk_exit", 8'h0C, 8'hA0);
    // flash mode entry, toggling, ped accumulation and exit on a tick only
    cyc(25);
    ui_in = 8'h04;
    cyc(1);
    expect_out("flash_entry", 8'h12, 8'h07);
    cyc(10);
    expect_out("flash_off", 8'h00, 8'h07);
    cyc(10);
    expect_out("flash_on", 8'h12, 8'h07);
    ui_in = 8'h06;
    cyc(1);
    ui_in = 8'h00;
    expect_out("flash_ped", 8'h92, 8'h07);
    cyc(8);
    expect_out("flash_wait_tick", 8'h92, 8'h07);
    cyc(1);
    expect_out("flash_exit", 8'h89, 8'h15);
    cyc(9);
    ui_in = 8'h02;
    cyc(1);
    ui_in = 8'h00;
    expect_out("walk_clear_wins", 8'h49, 8'h56);
    cyc(50);
    expect_out("walk_to_ns", 8'h0C, 8'hA0);
    // reset in the middle of EW yellow
    ui_in = 8'h01;
    cyc(100);
    expect_out("rst_ns_yellow", 8'h0A, 8'h31);
    ui_in = 8'h00;
    cyc(40);
    expect_out("rst_ew_green", 8'h21, 8'h63);
    cyc(60);
    expect_out("rst_ew_yellow", 8'h11, 8'h34);
    cyc(15);
    expect_out("rst_ew_yellow_mid", 8'h11, 8'h24);
    rst_n = 1'b0;
    cyc(1);
    expect_out("mid_reset", 8'h09, 8'h15);
    rst_n = 1'b1;
    cyc(10);
    expect_out("post_reset_ns", 8'h0C, 8'hA0);
    cyc(1);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
